// File: rtl/snake_pkg.sv
// Shared types and default timing constants for the Snake game controller.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    PAUSED    = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  localparam int unsigned TICK_BASE = 25_000_000;
  localparam int unsigned TICK_MIN  = 5_000_000;
  localparam int unsigned TICK_STEP = 250_000;
  localparam int unsigned OVER_HOLD = 100_000_000;
  localparam int unsigned BLINK_DIV = 12_500_000;

endpackage

// File: rtl/snake_tick_gen.sv
// Programmable-period pulse divider for the snake movement tick.
module snake_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        clear,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] cnt;
  logic        at_end;

  // A period shrink below the current count fires on the next run cycle.
  assign at_end = (cnt + 32'd1) >= period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (run) begin
      if (at_end) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 32'd1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game FSM, score-dependent move tick, hit qualification
// and game-over display blink.
module snake_game_ctrl #(
  parameter int unsigned SCORE_W   = 8,
  parameter int unsigned TICK_BASE = snake_pkg::TICK_BASE,
  parameter int unsigned TICK_MIN  = snake_pkg::TICK_MIN,
  parameter int unsigned TICK_STEP = snake_pkg::TICK_STEP,
  parameter int unsigned OVER_HOLD = snake_pkg::OVER_HOLD,
  parameter int unsigned BLINK_DIV = snake_pkg::BLINK_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               apple_hit,
  input  logic               wall_hit,
  input  logic               self_hit,
  input  logic [SCORE_W-1:0] score,
  output logic               move_tick,
  output logic               apple_eaten,
  output logic               collision,
  output logic               game_active,
  output logic               game_over,
  output logic               blink,
  output logic [1:0]         state
);

  import snake_pkg::*;

  localparam logic [31:0] HOLD_LAST  = 32'(OVER_HOLD - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
  localparam logic [31:0] DEC_MAX    = 32'(TICK_BASE - TICK_MIN);

  game_state_t state_q, state_d;

  logic start_prev, pause_prev, apple_prev;
  logic start_rise, pause_rise, apple_rise, coll_lvl;

  logic [31:0] hold_q, hold_d;
  logic [31:0] bcnt_q, bcnt_d;
  logic        blink_q, blink_d;
  logic        apple_d, coll_d;

  logic [31:0] dec;
  logic [31:0] period;
  logic        tick_run, tick_clear;

  assign start_rise = start_btn & ~start_prev;
  assign pause_rise = pause_btn & ~pause_prev;
  assign apple_rise = apple_hit & ~apple_prev;
  assign coll_lvl   = wall_hit | self_hit;

  // Clamp the reduction before subtracting so the period never underflows.
  assign dec    = 32'(score) * TICK_STEP;
  assign period = (dec >= DEC_MAX) ? 32'(TICK_MIN) : (32'(TICK_BASE) - dec);

  // Count only while staying in PLAYING, so the pause-edge cycle freezes the
  // count where it was sampled and resume picks up from that value.
  assign tick_run   = (state_q == PLAYING) && (state_d == PLAYING);
  assign tick_clear = (state_q == IDLE) || (state_q == GAME_OVER);

  snake_tick_gen u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (tick_run),
    .clear  (tick_clear),
    .period (period),
    .tick   (move_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
      apple_prev <= 1'b1;
    end else begin
      start_prev <= start_btn;
      pause_prev <= pause_btn;
      apple_prev <= apple_hit;
    end
  end

  always_comb begin
    state_d = state_q;
    apple_d = 1'b0;
    coll_d  = 1'b0;
    hold_d  = hold_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    unique case (state_q)
      IDLE: begin
        blink_d = 1'b1;
        if (start_rise) state_d = PLAYING;
      end
      PLAYING: begin
        if (coll_lvl) begin
          coll_d  = 1'b1;
          state_d = GAME_OVER;
          hold_d  = '0;
          bcnt_d  = '0;
          blink_d = 1'b0;
        end else if (pause_rise) begin
          state_d = PAUSED;
        end else if (apple_rise) begin
          apple_d = 1'b1;
        end
      end
      PAUSED: begin
        if (pause_rise) state_d = PLAYING;
      end
      GAME_OVER: begin
        if (hold_q != HOLD_LAST) hold_d = hold_q + 32'd1;
        if (bcnt_q == BLINK_LAST) begin
          bcnt_d  = '0;
          blink_d = ~blink_q;
        end else begin
          bcnt_d = bcnt_q + 32'd1;
        end
        if (start_rise && (hold_q == HOLD_LAST)) begin
          state_d = PLAYING;
          hold_d  = '0;
          bcnt_d  = '0;
          blink_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      bcnt_q      <= '0;
      blink_q     <= 1'b1;
      apple_eaten <= 1'b0;
      collision   <= 1'b0;
      game_active <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      bcnt_q      <= bcnt_d;
      blink_q     <= blink_d;
      apple_eaten <= apple_d;
      collision   <= coll_d;
      game_active <= (state_d == PLAYING);
      game_over   <= (state_d == GAME_OVER);
    end
  end

  assign state = state_q;
  assign blink = blink_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed self-checking bench for snake_game_ctrl with shortened timing.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_btn, pause_btn, apple_hit, wall_hit, self_hit;
  logic [7:0] score;
  logic       move_tick, apple_eaten, collision, game_active, game_over, blink;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  snake_game_ctrl #(
    .SCORE_W   (8),
    .TICK_BASE (10),
    .TICK_MIN  (4),
    .TICK_STEP (2),
    .OVER_HOLD (20),
    .BLINK_DIV (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_btn   (start_btn),
    .pause_btn   (pause_btn),
    .apple_hit   (apple_hit),
    .wall_hit    (wall_hit),
    .self_hit    (self_hit),
    .score       (score),
    .move_tick   (move_tick),
    .apple_eaten (apple_eaten),
    .collision   (collision),
    .game_active (game_active),
    .game_over   (game_over),
    .blink       (blink),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cy();
    @(posedge clk);
    #1;
  endtask

  // Cycles until the next move_tick, or -1 if none within the budget.
  task automatic cycles_to_tick(output int n);
    bit found;
    n = -1;
    found = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (!found) begin
        cy();
        if (move_tick) begin
          n = i;
          found = 1'b1;
        end
      end
    end
  endtask

  int n;
  int cnt_a, cnt_c, cnt_t;

  initial begin
    rst_n = 1'b0; start_btn = 1'b1; pause_btn = 1'b0;
    apple_hit = 1'b0; wall_hit = 1'b0; self_hit = 1'b0; score = 8'd0;

    // Reset with start held high
    repeat (3) cy();
    check("rst_state", 32'(state), 0);
    check("rst_blink", 32'(blink), 1);
    check("rst_outs", {move_tick, apple_eaten, collision, game_active, game_over}, 0);
    rst_n = 1'b1;
    repeat (3) cy();
    check("held_start_idle", 32'(state), 0);
    start_btn = 1'b0;
    cy();
    start_btn = 1'b1;
    cy();
    check("start_playing", 32'(state), 1);
    check("start_active", 32'(game_active), 1);
    start_btn = 1'b0;
    cycles_to_tick(n);
    check("first_tick", n, 10);
    cycles_to_tick(n);
    check("tick_period10", n, 10);

    // Score-driven period, including mid-count shrink
    repeat (7) cy();
    score = 8'd3;
    cycles_to_tick(n);
    check("shrink_midcount", n, 1);
    cycles_to_tick(n);
    check("tick_period4", n, 4);
    score = 8'd5;
    cycles_to_tick(n);
    check("tick_clamped", n, 4);

    // Apple held for 8 cycles
    apple_hit = 1'b1;
    cy();
    check("apple_latency", 32'(apple_eaten), 1);
    cnt_a = 1;
    for (int i = 0; i < 7; i++) begin cy(); cnt_a += int'(apple_eaten); end
    apple_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin cy(); cnt_a += int'(apple_eaten); end
    check("apple_once", cnt_a, 1);

    // Apple and wall together
    apple_hit = 1'b1; wall_hit = 1'b1;
    cy();
    check("coll_pulse", 32'(collision), 1);
    check("coll_no_apple", 32'(apple_eaten), 0);
    check("coll_state", 32'(state), 3);
    check("coll_inactive", 32'(game_active), 0);
    check("coll_over", 32'(game_over), 1);
    check("coll_blink0", 32'(blink), 0);
    apple_hit = 1'b0; wall_hit = 1'b0;
    cnt_a = 0; cnt_c = 0;
    for (int i = 1; i <= 9; i++) begin
      cy();
      check($sformatf("blink_c%0d", i), 32'(blink), 32'((i / 5) % 2));
      cnt_a += int'(apple_eaten);
      cnt_c += int'(collision);
    end
    check("over_no_apple", cnt_a, 0);
    check("over_no_coll", cnt_c, 0);

    // Start during hold ignored, accepted after hold
    start_btn = 1'b1;
    cy();
    check("hold_start_ignored", 32'(state), 3);
    check("blink_c10", 32'(blink), 0);
    start_btn = 1'b0;
    for (int i = 11; i <= 21; i++) cy();
    check("still_over", 32'(state), 3);
    start_btn = 1'b1; score = 8'd0;
    cy();
    check("restart_state", 32'(state), 1);
    check("restart_blink", 32'(blink), 1);
    check("restart_over", 32'(game_over), 0);
    start_btn = 1'b0;
    cycles_to_tick(n);
    check("restart_tick", n, 10);

    // Pause at count 6, resume
    repeat (6) cy();
    pause_btn = 1'b1;
    cy();
    check("paused_state", 32'(state), 2);
    pause_btn = 1'b0;
    cnt_a = 0; cnt_t = 0;
    for (int i = 1; i <= 50; i++) begin
      cy();
      cnt_a += int'(apple_eaten);
      cnt_t += int'(move_tick);
      if (i == 20) apple_hit = 1'b1;
      if (i == 25) apple_hit = 1'b0;
      if (i == 30) start_btn = 1'b1;
      if (i == 32) start_btn = 1'b0;
    end
    check("pause_no_tick", cnt_t, 0);
    check("pause_no_apple", cnt_a, 0);
    check("pause_hold", 32'(state), 2);
    pause_btn = 1'b1;
    cy();
    check("resume_state", 32'(state), 1);
    pause_btn = 1'b0;
    cycles_to_tick(n);
    check("resume_tick", n, 4);

    // Asynchronous reset while a tick pulse is high
    repeat (10) cy();
    check("tick_before_rst", 32'(move_tick), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_tick", 32'(move_tick), 0);
    check("async_state", 32'(state), 0);
    check("async_blink", 32'(blink), 1);
    check("async_active", 32'(game_active), 0);
    repeat (2) cy();
    rst_n = 1'b1;
    cy();
    check("post_rst_idle", 32'(state), 0);

    // Start and pause together from IDLE
    start_btn = 1'b1; pause_btn = 1'b1;
    cy();
    check("start_beats_pause", 32'(state), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
